// File: rtl/xp_pkg.sv
// Shared types and constants for the xp FIFO consumer path.
package xp_pkg;

    localparam int XP_DATA_W = 32;

    typedef logic [1:0] keep_t;

    localparam keep_t KEEP_FULL = 2'b11;
    localparam keep_t KEEP_HALF = 2'b01;

    typedef struct packed {
        logic [2*XP_DATA_W-1:0] data;
        keep_t                  keep;
        logic                   last;
    } xp_beat_t;

endpackage

// File: rtl/xp_sat_cnt.sv
// Purpose: CNT_W-bit event counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an inc pulse on the following cycle.
// Backpressure: none; an inc while saturated is dropped.
module xp_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/xp_deq_packer.sv
// Purpose: drain the xp FIFO and pair consecutive words into 2-word beats; flush emits a held odd word.
// Latency: beat valid 1 cycle after the second word's data arrives (2 cycles after its deq).
// Backpressure: m_ready low stalls the beat; at most one beat plus one held word, then deq stops.
module xp_deq_packer
    import xp_pkg::*;
#(
    parameter int DATA_W = XP_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    output logic                fifo_deq,
    input  logic [DATA_W-1:0]   fifo_dout,
    input  logic                flush,
    output logic                flush_ack,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*DATA_W-1:0] m_data,
    output keep_t               m_keep,
    output logic                m_last,
    output logic [CNT_W-1:0]    words_rd,
    output logic [CNT_W-1:0]    beats_out
);

    logic              rd_pend;
    logic              lo_vld;
    logic [DATA_W-1:0] lo_q;

    logic [2*DATA_W-1:0] data_q;
    keep_t               keep_q;
    logic                last_q;
    logic                out_vld;
    logic                ack_q;

    logic pair_load;
    logic flush_done;
    logic half_load;
    logic xfer;

    // Issue only when the arriving word is guaranteed a slot: either lo is free
    // or the output register is free to take the completed pair.
    assign fifo_deq = !rst && !fifo_empty && !rd_pend && !flush && (!lo_vld || !out_vld);

    assign xfer      = out_vld && m_ready;
    assign pair_load = rd_pend && lo_vld;

    // ack_q masks the cycle right after completion so a requester that drops
    // flush on seeing flush_ack never gets a second pulse.
    assign flush_done = flush && !ack_q && !rd_pend && (!lo_vld || !out_vld || m_ready);
    assign half_load  = flush_done && lo_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            lo_vld  <= 1'b0;
            lo_q    <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            out_vld <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            rd_pend <= fifo_deq;
            ack_q   <= flush_done;

            if (rd_pend && !lo_vld) begin
                lo_q   <= fifo_dout;
                lo_vld <= 1'b1;
            end else if (pair_load || half_load) begin
                lo_vld <= 1'b0;
            end

            if (pair_load) begin
                data_q  <= {fifo_dout, lo_q};
                keep_q  <= KEEP_FULL;
                last_q  <= 1'b0;
                out_vld <= 1'b1;
            end else if (half_load) begin
                data_q  <= {{DATA_W{1'b0}}, lo_q};
                keep_q  <= KEEP_HALF;
                last_q  <= 1'b1;
                out_vld <= 1'b1;
            end else if (xfer) begin
                out_vld <= 1'b0;
            end
        end
    end

    assign m_valid   = out_vld;
    assign m_data    = data_q;
    assign m_keep    = keep_q;
    assign m_last    = last_q;
    assign flush_ack = ack_q;

    xp_sat_cnt #(.CNT_W(CNT_W)) u_words_cnt (
        .clk (clk),
        .rst (rst),
        .inc (rd_pend),
        .cnt (words_rd)
    );

    xp_sat_cnt #(.CNT_W(CNT_W)) u_beats_cnt (
        .clk (clk),
        .rst (rst),
        .inc (xfer),
        .cnt (beats_out)
    );

endmodule

// File: tb/tb_xp_deq_packer.sv
// Scoreboarded bench for xp_deq_packer with a behavioural registered-read FIFO.
module tb_xp_deq_packer;
    import xp_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_deq;
    logic [DW-1:0] fifo_dout = '0;
    logic          flush = 1'b0;
    logic          flush_ack;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [2*DW-1:0] m_data;
    logic [1:0]    m_keep;
    logic          m_last;
    logic [CW-1:0] words_rd;
    logic [CW-1:0] beats_out;

    logic       sc_rst = 1'b1;
    logic       sc_inc = 1'b0;
    logic [3:0] sc_cnt;

    int checks = 0;
    int errors = 0;
    int deq_cnt = 0;
    logic prev_deq = 1'b0;

    logic [DW-1:0]     fq[$];
    logic [2*DW+2:0]   exp_q[$];
    logic [DW-1:0]     lo_m = '0;
    bit                have_lo = 1'b0;

    always #5 clk = ~clk;

    xp_deq_packer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_deq   (fifo_deq),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .flush_ack  (flush_ack),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .words_rd   (words_rd),
        .beats_out  (beats_out)
    );

    xp_sat_cnt #(.CNT_W(4)) u_sat (
        .clk (clk),
        .rst (sc_rst),
        .inc (sc_inc),
        .cnt (sc_cnt)
    );

    // FIFO model: read data appears the cycle after the deq strobe
    always @(posedge clk) begin
        if (fifo_deq && !rst && fq.size() > 0) fifo_dout <= fq.pop_front();
    end

    always @(posedge clk) begin
        #2;
        fifo_empty = (fq.size() == 0);
    end

    always @(negedge clk) begin
        logic [2*DW+2:0] e;
        if (rst) begin
            prev_deq = 1'b0;
        end else begin
            if (fifo_deq) begin
                deq_cnt++;
                checks++;
                if (prev_deq) begin
                    errors++;
                    $display("FAIL deq_spacing: fifo_deq=1 two cycles in a row, required a gap");
                end
            end
            prev_deq = fifo_deq;
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: beat data=%h keep=%b last=%b, required no beat", m_data, m_keep, m_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_data, m_keep, m_last} !== e) begin
                        errors++;
                        $display("FAIL sb_beat: got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                                 m_data, m_keep, m_last, e[2*DW+2:3], e[2:1], e[0]);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        fq.delete();
        exp_q.delete();
        have_lo = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        if (have_lo) begin
            exp_q.push_back({w, lo_m, KEEP_FULL, 1'b0});
            have_lo = 1'b0;
        end else begin
            lo_m = w;
            have_lo = 1'b1;
        end
    endtask

    task automatic model_flush;
        if (have_lo) begin
            exp_q.push_back({{DW{1'b0}}, lo_m, KEEP_HALF, 1'b1});
            have_lo = 1'b0;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (fq.size() == 0 && exp_q.size() == 0 && !m_valid && !dut.rd_pend) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (words_rd == n[CW-1:0]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL rst_m_valid: got %b, required 0", m_valid); end
        checks++; if (fifo_deq !== 1'b0)  begin errors++; $display("FAIL rst_fifo_deq: got %b, required 0", fifo_deq); end
        checks++; if (flush_ack !== 1'b0) begin errors++; $display("FAIL rst_flush_ack: got %b, required 0", flush_ack); end
        checks++; if ({m_data, m_keep, m_last} !== '0) begin errors++; $display("FAIL rst_beat: got %h/%b/%b, required 0", m_data, m_keep, m_last); end
        checks++; if (words_rd !== '0 || beats_out !== '0) begin errors++; $display("FAIL rst_counters: got %0d/%0d, required 0/0", words_rd, beats_out); end
        rst = 1'b0;
    endtask

    task automatic test_pairs;
        bit ok;
        do_reset();
        m_ready = 1'b1;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL pairs_drain: timed out, required drained within 200 cycles"); end
        checks++; if (words_rd !== 16'd4) begin errors++; $display("FAIL pairs_words_rd: got %0d, required 4", words_rd); end
        checks++; if (beats_out !== 16'd2) begin errors++; $display("FAIL pairs_beats_out: got %0d, required 2", beats_out); end
    endtask

    task automatic test_flush_odd;
        bit ok;
        int acks;
        do_reset();
        m_ready = 1'b1;
        push_word(32'hA); push_word(32'hB); push_word(32'hC);
        wait_words(3, ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_odd_words: got %0d, required 3", words_rd); end
        model_flush();
        flush = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (flush_ack) begin
                acks++;
                flush = 1'b0;
            end
        end
        flush = 1'b0;
        checks++; if (acks != 1) begin errors++; $display("FAIL flush_odd_acks: got %0d pulses, required 1", acks); end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL flush_odd_drain: timed out, required drained"); end
        checks++; if (dut.lo_vld !== 1'b0) begin errors++; $display("FAIL flush_odd_lo_vld: got %b, required 0", dut.lo_vld); end
        checks++; if (beats_out !== 16'd2) begin errors++; $display("FAIL flush_odd_beats: got %0d, required 2", beats_out); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int base;
        do_reset();
        base = deq_cnt;
        for (int i = 1; i <= 6; i++) push_word(32'h100 + i);
        for (int i = 0; i < 10; i++) tick();
        checks++; if (deq_cnt - base != 3) begin errors++; $display("FAIL bp_deq_count: got %0d, required 3", deq_cnt - base); end
        checks++; if (m_valid !== 1'b1 || m_data !== {32'h102, 32'h101} || m_keep !== KEEP_FULL) begin
            errors++; $display("FAIL bp_stall_beat: got v=%b data=%h keep=%b, required v=1 data=%h keep=11", m_valid, m_data, m_keep, {32'h102, 32'h101});
        end
        checks++; if (dut.lo_vld !== 1'b1) begin errors++; $display("FAIL bp_held: got lo_vld=%b, required 1", dut.lo_vld); end
        m_ready = 1'b1;
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_drain: timed out, required drained"); end
        checks++; if (words_rd !== 16'd6 || beats_out !== 16'd3) begin errors++; $display("FAIL bp_counters: got %0d/%0d, required 6/3", words_rd, beats_out); end
    endtask

    task automatic test_flush_idle;
        do_reset();
        flush = 1'b1;
        tick();
        checks++; if (flush_ack !== 1'b1) begin errors++; $display("FAIL idle_ack: got %b, required 1", flush_ack); end
        flush = 1'b0;
        tick();
        checks++; if (flush_ack !== 1'b0) begin errors++; $display("FAIL idle_ack_pulse: got %b, required 0", flush_ack); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL idle_m_valid: got %b, required 0", m_valid); end
    endtask

    task automatic test_flush_at_arrival;
        bit ok;
        do_reset();
        m_ready = 1'b1;
        push_word(32'hD1); push_word(32'hD2);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (dut.rd_pend && dut.lo_vld) begin ok = 1'b1; break; end
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL arr_wait: timed out, required second arrival pending"); end
        flush = 1'b1;
        tick();
        checks++; if (m_valid !== 1'b1 || m_keep !== KEEP_FULL || flush_ack !== 1'b0) begin
            errors++; $display("FAIL arr_beat_first: got v=%b keep=%b ack=%b, required v=1 keep=11 ack=0", m_valid, m_keep, flush_ack);
        end
        tick();
        checks++; if (flush_ack !== 1'b1) begin errors++; $display("FAIL arr_ack: got %b, required 1", flush_ack); end
        flush = 1'b0;
        tick();
        checks++; if (m_valid !== 1'b0 || beats_out !== 16'd1) begin
            errors++; $display("FAIL arr_no_half: got v=%b beats=%0d, required v=0 beats=1", m_valid, beats_out);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        push_word(32'hE1); push_word(32'hE2); push_word(32'hE3);
        wait_words(3, ok);
        checks++; if (!ok || m_valid !== 1'b1 || dut.lo_vld !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got words=%0d v=%b lo=%b, required 3/1/1", words_rd, m_valid, dut.lo_vld);
        end
        rst = 1'b1;
        exp_q.delete();
        have_lo = 1'b0;
        tick();
        checks++; if ({m_valid, fifo_deq, flush_ack, m_data, m_keep, m_last} !== '0 || dut.lo_vld !== 1'b0) begin
            errors++; $display("FAIL mid_rst_outputs: got v=%b deq=%b ack=%b data=%h lo=%b, required all 0", m_valid, fifo_deq, flush_ack, m_data, dut.lo_vld);
        end
        checks++; if (words_rd !== '0 || beats_out !== '0) begin errors++; $display("FAIL mid_rst_counters: got %0d/%0d, required 0/0", words_rd, beats_out); end
        rst = 1'b0;
        m_ready = 1'b1;
        push_word(32'h55); push_word(32'h66);
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_drain: timed out, required drained"); end
        checks++; if (words_rd !== 16'd2 || beats_out !== 16'd1) begin errors++; $display("FAIL mid_counters: got %0d/%0d, required 2/1", words_rd, beats_out); end
    endtask

    task automatic test_saturation;
        sc_rst = 1'b1;
        tick();
        checks++; if (sc_cnt !== 4'd0) begin errors++; $display("FAIL sat_reset: got %0d, required 0", sc_cnt); end
        sc_rst = 1'b0;
        sc_inc = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (sc_cnt !== 4'd14) begin errors++; $display("FAIL sat_count: got %0d, required 14", sc_cnt); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (sc_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d, required 15", sc_cnt); end
        sc_inc = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pairs();
        test_flush_odd();
        test_backpressure();
        test_flush_idle();
        test_flush_at_arrival();
        test_reset_mid();
        test_saturation();
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL sb_leftover: %0d beats never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/xp_deq_packer.md
Name: xp_deq_packer

Overview:
- Downstream consumer of the xp FIFO (enq/deq/din, 32-bit words).
- Issues deq requests, captures the FIFO's registered read data, and pairs consecutive 32-bit words into 64-bit beats on a valid/ready output stream.
- A flush request emits a lone held word as a half-beat.
- Keeps running counts of words consumed and beats delivered for debug and status.

Parameters:
- DATA_W, 32, FIFO word width; the output beat is 2*DATA_W wide.
- CNT_W, 16, width of the status counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO has no readable word.
- fifo_deq  out  1  read strobe to the FIFO; one word per asserted cycle.
- fifo_dout  in  DATA_W  FIFO read data, valid on the cycle after fifo_deq.
- flush  in  1  level request to emit a held odd word; held until flush_ack.
- flush_ack  out  1  one-cycle pulse when the flush completes.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the beat.
- m_data  out  2*DATA_W  {hi word, lo word}; the lo word is the older word.
- m_keep  out  2  word enables: 2'b11 for a full beat, 2'b01 for a flushed half-beat.
- m_last  out  1  set only on flushed half-beats.
- words_rd  out  CNT_W  FIFO words consumed (saturating).
- beats_out  out  CNT_W  beats accepted downstream (saturating).

Behaviour:
- Reset: all outputs and state are 0 in the cycle after rst is sampled high; this includes fifo_deq, m_valid, flush_ack and both counters.
  - Reset mid-operation drops the held word, any in-flight read and the output beat.
  - The FIFO word in flight on that cycle is lost. This is accepted.
- Internal state:
  - rd_pend: a deq was issued last cycle.
  - lo_q/lo_vld: held older word.
  - out register: m_data, m_keep, m_last, m_valid.
- Issue rule, combinational from registers and inputs: fifo_deq = !fifo_empty & !rd_pend & !flush & (!lo_vld | !m_valid).
  - This guarantees space for the arriving word.
  - Peak rate is one word per 2 cycles; the downstream is not the bottleneck.
- Arrival (rd_pend=1):
  - If !lo_vld: lo_q <= fifo_dout and lo_vld <= 1.
  - Otherwise: m_data <= {fifo_dout, lo_q}, m_keep <= 2'b11, m_last <= 0, m_valid <= 1, lo_vld <= 0.
  - words_rd increments by 1 on every arrival.
- Output handshake:
  - A beat transfers when m_valid & m_ready.
  - m_valid clears on transfer unless a new beat loads in the same cycle; then it stays 1 with the new data.
  - While m_valid & !m_ready, m_data, m_keep and m_last stay stable.
  - beats_out increments on every transfer.
- Flush:
  - While flush=1, no new deq is issued.
  - The flush completes on the first cycle with !rd_pend and either:
    - lo_vld & (!m_valid | m_ready): load m_data <= {0, lo_q}, m_keep <= 2'b01, m_last <= 1, clear lo_vld, pulse flush_ack.
    - !lo_vld: pulse flush_ack only; no beat is emitted.
  - flush_ack does not wait for the output beat to drain.
  - Flush sampled in the same cycle as an arrival is deferred one cycle; the arrival is processed first.
- Counters saturate at all-ones and do not wrap.
- A FIFO that is empty when the packer is idle produces no activity.
- fifo_empty is sampled only at issue time and is never rechecked for an in-flight read.

Decomposition:
- Package xp_pkg:
  - XP_DATA_W = 32.
  - typedef keep_t (2-bit).
  - constants KEEP_FULL = 2'b11 and KEEP_HALF = 2'b01.
  - typedef xp_beat_t packed struct {data, keep, last}.
- One natural sub-module: xp_sat_cnt (CNT_W saturating incrementer), instantiated twice.
- Issue logic and pairing stay in the top module.

Test Plan:
1. Reset, then FIFO holds 4 words 0x11,0x22,0x33,0x44 with m_ready=1 -> beats {0x22,0x11} then {0x44,0x33}, keep=11, last=0; words_rd=4, beats_out=2; fifo_deq never high on consecutive cycles.
2. 3 words 0xA,0xB,0xC, then flush held high -> beat {0xB,0xA}, then beat {0,0xC} with keep=01, last=1; exactly one flush_ack pulse; lo_vld=0 afterwards.
3. m_ready=0 for 10 cycles with 6 words available -> exactly 3 deq strobes issued (one beat pending + one word held), then stall; m_data stable; on m_ready=1 the remaining beats drain in order; words_rd=6.
4. Flush with no held word and an idle FIFO -> flush_ack pulses within 1 cycle, m_valid stays 0.
5. Flush asserted in the cycle a second word arrives -> the full beat forms first, flush_ack fires next cycle with no half-beat.
6. rst asserted while a beat is pending and a word is held -> next cycle all outputs are 0; the first two post-reset words form a fresh beat; counters restart from 0.
